dbc_port_fsm_array: RTL

- Parametrised successor of the single-port DbC port state machine.
- Tracks NUM_PORTS independent DbC port state machines in one block, all clocked and enabled together.
- Adds a reset-timeout timer, per-port saturating error counters and registered state outputs.
- Sits between the DbC capability/port-status register decode and the DbC transfer engine.
- The transfer engine uses the `configured` vector to gate traffic per port.

---
 rtl/dbc_port_fsm_array.sv | 257 +++++++++++++++++++++++++
 1 files changed

// File: rtl/dbc_port_fsm_array.sv
// -----------------------------------------------------------------------------
// dbc_port_fsm_array
//
// Purpose:
//   NUM_PORTS independent DbC port state machines that share one clock and one
//   DbC enable. Each port has a reset-timeout timer, a saturating error counter
//   and registered state outputs. The transfer engine uses `configured` to gate
//   traffic on each port.
//
// Optional feature:
//   Define DBC_STATE_CHANGE_IRQ_EN to add irq_clr/irq. These give a sticky
//   per-port interrupt that sets on any port_state change.
//
// Ports:
//   clock          block clock; all state updates happen on the rising edge
//   reset_n        asynchronous active-low reset
//   dce            DbC enable, common to all ports
//   csc, plc, prc, ped, cec, reset_rcvd, set_config_ok, enum_error,
//   deconfigure    per-port event/status inputs, [NUM_PORTS]
//   port_state     current state; port i occupies bits [5i+4:5i]
//   configured     1 while the port is in CONFIGURED
//   timeout_err    1-cycle pulse when a port's reset timer expires
//   err_count      per-port saturating count of entries into ERROR
//   irq_clr / irq  (DBC_STATE_CHANGE_IRQ_EN only) sticky state-change irq
// -----------------------------------------------------------------------------
module dbc_port_fsm_array #(
    parameter int NUM_PORTS     = 2,
    parameter int RESET_TIMEOUT = 1024,
    parameter int TIMER_W       = 12,
    parameter int ERR_CNT_W     = 4
) (
    input  logic                           clock,
    input  logic                           reset_n,
    input  logic                           dce,
    input  logic [NUM_PORTS-1:0]           csc,
    input  logic [NUM_PORTS-1:0]           plc,
    input  logic [NUM_PORTS-1:0]           prc,
    input  logic [NUM_PORTS-1:0]           ped,
    input  logic [NUM_PORTS-1:0]           cec,
    input  logic [NUM_PORTS-1:0]           reset_rcvd,
    input  logic [NUM_PORTS-1:0]           set_config_ok,
    input  logic [NUM_PORTS-1:0]           enum_error,
    input  logic [NUM_PORTS-1:0]           deconfigure,
`ifdef DBC_STATE_CHANGE_IRQ_EN
    input  logic [NUM_PORTS-1:0]           irq_clr,
    output logic [NUM_PORTS-1:0]           irq,
`endif
    output logic [5*NUM_PORTS-1:0]         port_state,
    output logic [NUM_PORTS-1:0]           configured,
    output logic [NUM_PORTS-1:0]           timeout_err,
    output logic [ERR_CNT_W*NUM_PORTS-1:0] err_count
);

    typedef enum logic [4:0] {
        ST_OFF          = 5'b00000,
        ST_DISCONNECTED = 5'b10000,
        ST_DISABLED     = 5'b10001,
        ST_ENABLED      = 5'b10010,
        ST_RESETTING    = 5'b11010,
        ST_ERROR        = 5'b11000,
        ST_CONFIGURED   = 5'b11101
    } port_state_e;

    localparam logic [TIMER_W-1:0]   TIMER_LAST = TIMER_W'(RESET_TIMEOUT - 1);
    localparam logic [TIMER_W-1:0]   TIMER_ZERO = {TIMER_W{1'b0}};
    localparam logic [ERR_CNT_W-1:0] ERR_ZERO   = {ERR_CNT_W{1'b0}};

    // Saturating increment: the counter sticks at all-ones instead of wrapping.
    function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
        logic [ERR_CNT_W-1:0] r;
        if (v == {ERR_CNT_W{1'b1}}) begin
            r = v;
        end else begin
            r = v + ERR_CNT_W'(1);
        end
        return r;
    endfunction

    port_state_e          state_r      [NUM_PORTS];
    port_state_e          state_next_s [NUM_PORTS];
    logic [TIMER_W-1:0]   timer_r      [NUM_PORTS];
    logic [TIMER_W-1:0]   timer_next_s [NUM_PORTS];
    logic [ERR_CNT_W-1:0] err_r        [NUM_PORTS];
    logic [ERR_CNT_W-1:0] err_next_s   [NUM_PORTS];
    logic [NUM_PORTS-1:0] configured_r;
    logic [NUM_PORTS-1:0] configured_next_s;
    logic [NUM_PORTS-1:0] timeout_r;
    logic [NUM_PORTS-1:0] timeout_next_s;

    // Per-port next-state, timer, error-count and output-pulse logic.
    always_comb begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            state_next_s[i]      = state_r[i];
            timer_next_s[i]      = timer_r[i];
            err_next_s[i]        = err_r[i];
            timeout_next_s[i]    = 1'b0;
            configured_next_s[i] = 1'b0;

            if (!dce) begin
                // Disable overrides everything; error history is kept.
                state_next_s[i] = ST_OFF;
                timer_next_s[i] = TIMER_ZERO;
            end else begin
                case (state_r[i])
                    ST_OFF: begin
                        state_next_s[i] = ST_DISCONNECTED;
                    end
                    ST_DISCONNECTED: begin
                        if (csc[i]) begin
                            state_next_s[i] = ST_ENABLED;
                        end else begin
                            state_next_s[i] = ST_DISCONNECTED;
                        end
                    end
                    ST_DISABLED: begin
                        if (csc[i]) begin
                            state_next_s[i] = ST_DISCONNECTED;
                        end else if (ped[i]) begin
                            state_next_s[i] = ST_ENABLED;
                        end else begin
                            state_next_s[i] = ST_DISABLED;
                        end
                    end
                    ST_ENABLED: begin
                        if (csc[i]) begin
                            state_next_s[i] = ST_DISCONNECTED;
                        end else if (!ped[i] || cec[i] || plc[i]) begin
                            state_next_s[i] = ST_DISABLED;
                        end else if (enum_error[i]) begin
                            state_next_s[i] = ST_ERROR;
                            err_next_s[i]   = sat_inc(err_r[i]);
                        end else if (reset_rcvd[i]) begin
                            state_next_s[i] = ST_RESETTING;
                            timer_next_s[i] = TIMER_ZERO;
                        end else if (set_config_ok[i]) begin
                            state_next_s[i] = ST_CONFIGURED;
                        end else begin
                            state_next_s[i] = ST_ENABLED;
                        end
                    end
                    ST_RESETTING: begin
                        // prc is checked before the timeout, so a completion
                        // on the final cycle wins and no pulse is produced.
                        if (csc[i]) begin
                            state_next_s[i] = ST_DISCONNECTED;
                        end else if (!ped[i]) begin
                            state_next_s[i] = ST_DISABLED;
                        end else if (prc[i]) begin
                            state_next_s[i] = ST_ENABLED;
                        end else if (timer_r[i] == TIMER_LAST) begin
                            state_next_s[i]   = ST_ERROR;
                            timeout_next_s[i] = 1'b1;
                            err_next_s[i]     = sat_inc(err_r[i]);
                        end else begin
                            state_next_s[i] = ST_RESETTING;
                            timer_next_s[i] = timer_r[i] + TIMER_W'(1);
                        end
                    end
                    ST_ERROR: begin
                        if (csc[i]) begin
                            state_next_s[i] = ST_DISCONNECTED;
                        end else if (!ped[i]) begin
                            state_next_s[i] = ST_DISABLED;
                        end else if (reset_rcvd[i]) begin
                            state_next_s[i] = ST_RESETTING;
                            timer_next_s[i] = TIMER_ZERO;
                        end else begin
                            state_next_s[i] = ST_ERROR;
                        end
                    end
                    ST_CONFIGURED: begin
                        if (csc[i]) begin
                            state_next_s[i] = ST_DISCONNECTED;
                        end else if (!ped[i]) begin
                            state_next_s[i] = ST_DISABLED;
                        end else if (reset_rcvd[i]) begin
                            state_next_s[i] = ST_RESETTING;
                            timer_next_s[i] = TIMER_ZERO;
                        end else if (deconfigure[i]) begin
                            state_next_s[i] = ST_ENABLED;
                        end else begin
                            state_next_s[i] = ST_CONFIGURED;
                        end
                    end
                    default: begin
                        // Unused encodings recover to OFF.
                        state_next_s[i] = ST_OFF;
                    end
                endcase
            end

            // Derived from the next state so it lines up with port_state.
            configured_next_s[i] = (state_next_s[i] == ST_CONFIGURED);
        end
    end

    // State, timer, counter and registered-output flops for every port.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                state_r[i] <= ST_OFF;
                timer_r[i] <= TIMER_ZERO;
                err_r[i]   <= ERR_ZERO;
            end
            configured_r <= {NUM_PORTS{1'b0}};
            timeout_r    <= {NUM_PORTS{1'b0}};
        end else begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                state_r[i] <= state_next_s[i];
                timer_r[i] <= timer_next_s[i];
                err_r[i]   <= err_next_s[i];
            end
            configured_r <= configured_next_s;
            timeout_r    <= timeout_next_s;
        end
    end

`ifdef DBC_STATE_CHANGE_IRQ_EN
    logic [NUM_PORTS-1:0] irq_r;
    logic [NUM_PORTS-1:0] irq_next_s;

    // Sticky irq: a state change in the same cycle as a clear keeps it set.
    always_comb begin
        irq_next_s = irq_r & ~irq_clr;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (state_next_s[i] != state_r[i]) begin
                irq_next_s[i] = 1'b1;
            end else begin
                irq_next_s[i] = irq_r[i] & ~irq_clr[i];
            end
        end
    end

    // Interrupt register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            irq_r <= {NUM_PORTS{1'b0}};
        end else begin
            irq_r <= irq_next_s;
        end
    end

    assign irq = irq_r;
`endif

    genvar g;
    generate
        for (g = 0; g < NUM_PORTS; g++) begin : g_out
            assign port_state[5*g +: 5]                = state_r[g];
            assign err_count[ERR_CNT_W*g +: ERR_CNT_W] = err_r[g];
        end
    endgenerate

    assign configured  = configured_r;
    assign timeout_err = timeout_r;

endmodule
